// File: rtl/debug_ram_capture_ctrl.sv
// debug_ram_capture_ctrl: pre/post-trigger capture sequencer filling one port of a 512x32 debug RAM,
// controlled and polled through a small Avalon-MM register slave.
module debug_ram_capture_ctrl #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              trigger_in,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write,
    input  logic              read,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic [3:0]        ram_byteenable,
    output logic              capture_done
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] PRETRIG = 3'd1;
    localparam logic [2:0] ARMED   = 3'd2;
    localparam logic [2:0] POST    = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;
    localparam logic [ADDR_W:0] DEPTH = ADDR_W'(1) << ADDR_W;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [ADDR_W:0]   post_cnt_q, post_cnt_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] pre_len_q, pre_len_d;
    logic [ADDR_W-1:0] pre_len_csr_q, pre_len_csr_d;
    logic              trig_d_q;
    logic [31:0]       readdata_q, readdata_d;
    logic [ADDR_W-1:0] ram_address_q;
    logic              ram_write_q;
    logic [DATA_W-1:0] ram_writedata_q;

    logic              ctrl_wr, arm, abort, force_trig, active, accept, trig_ev;
    logic [ADDR_W-1:0] pre_inc;
    logic [ADDR_W:0]   post_inc, post_len;

    assign ctrl_wr    = chipselect & write & (address == 2'd0);
    assign arm        = ctrl_wr & writedata[0];
    assign abort      = ctrl_wr & writedata[1];
    assign force_trig = ctrl_wr & writedata[2];
    assign active     = (state_q == PRETRIG) | (state_q == ARMED) | (state_q == POST);
    // A CTRL ARM/ABORT cycle restarts or stops the capture, so its sample is dropped
    assign accept     = sample_valid & active & ~arm & ~abort;
    assign trig_ev    = (trigger_in & ~trig_d_q) | force_trig;
    assign pre_inc    = pre_cnt_q + 1'b1;
    assign post_inc   = (state_q == ARMED ? '0 : post_cnt_q) + {{ADDR_W{1'b0}}, accept};
    assign post_len   = DEPTH - {1'b0, pre_len_q};

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
        pre_cnt_d   = pre_cnt_q;
        post_cnt_d  = post_cnt_q;
        trig_addr_d = trig_addr_q;
        pre_len_d   = pre_len_q;
        if (abort) begin
            state_d = IDLE;
        end else if (arm) begin
            wr_ptr_d   = '0;
            pre_cnt_d  = '0;
            post_cnt_d = '0;
            pre_len_d  = pre_len_csr_q;
            state_d    = (pre_len_csr_q == '0) ? ARMED : PRETRIG;
        end else begin
            case (state_q)
                PRETRIG: if (accept) begin
                    pre_cnt_d = pre_inc;
                    state_d   = (pre_inc == pre_len_q) ? ARMED : PRETRIG;
                end
                ARMED: if (trig_ev) begin
                    trig_addr_d = wr_ptr_q;
                    post_cnt_d  = post_inc;
                    state_d     = (post_inc == post_len) ? DONE : POST;
                end
                POST: begin
                    post_cnt_d = post_inc;
                    state_d    = (post_inc == post_len) ? DONE : POST;
                end
                default: ;
            endcase
        end
    end

    assign pre_len_csr_d = (chipselect & write & (address == 2'd1))
                         ? (|writedata[31:ADDR_W] ? '1 : writedata[ADDR_W-1:0])
                         : pre_len_csr_q;

    always_comb begin
        readdata_d = readdata_q;
        if (chipselect & read) begin
            case (address)
                2'd1:    readdata_d = 32'(pre_len_csr_q);
                2'd2:    readdata_d = (32'(trig_addr_q) << 16) | {28'd0, state_q == DONE, state_q};
                2'd3:    readdata_d = 32'(wr_ptr_q);
                default: readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            wr_ptr_q        <= '0;
            pre_cnt_q       <= '0;
            post_cnt_q      <= '0;
            trig_addr_q     <= '0;
            pre_len_q       <= '0;
            pre_len_csr_q   <= '0;
            trig_d_q        <= 1'b0;
            readdata_q      <= '0;
            ram_address_q   <= '0;
            ram_write_q     <= 1'b0;
            ram_writedata_q <= '0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            pre_cnt_q       <= pre_cnt_d;
            post_cnt_q      <= post_cnt_d;
            trig_addr_q     <= trig_addr_d;
            pre_len_q       <= pre_len_d;
            pre_len_csr_q   <= pre_len_csr_d;
            trig_d_q        <= trigger_in;
            readdata_q      <= readdata_d;
            ram_address_q   <= accept ? wr_ptr_q : ram_address_q;
            ram_write_q     <= accept;
            ram_writedata_q <= accept ? sample_data : ram_writedata_q;
        end
    end

    assign readdata       = readdata_q;
    assign ram_address    = ram_address_q;
    assign ram_chipselect = ram_write_q;
    assign ram_write      = ram_write_q;
    assign ram_writedata  = ram_writedata_q;
    assign ram_byteenable = 4'hF;
    assign capture_done   = (state_q == DONE);
endmodule
